// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU packet controller.
package uart_alu_pkg;

  localparam int         WORD_W   = 32;
  localparam int         HDR_LEN  = 4;
  localparam logic [7:0] OPC_ECHO = 8'hEC;
  localparam logic [7:0] OPC_ADD  = 8'hA0;

  typedef enum logic [3:0] {
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_ECHO,
    ST_ECHO_FLUSH,
    ST_ADD_RX,
    ST_ADD_TX,
    ST_DRAIN
  } state_e;

  // Payload byte count: the header bytes are included in len.
  function automatic logic [15:0] payload_len(input logic [15:0] len);
    return (len > 16'(HDR_LEN)) ? (len - 16'(HDR_LEN)) : 16'd0;
  endfunction

endpackage

// File: rtl/uart_alu_skid.sv
// One-entry tx holding register; the owner only loads when the slot is free or draining.
module uart_alu_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/uart_alu_ctrl.sv
// Packet sequencer: parses a 4-byte header from the rx stream, then echoes,
// sums or drains the payload and streams any response to the tx side.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter logic [7:0] OPC_ECHO_P = OPC_ECHO,
  parameter logic [7:0] OPC_ADD_P  = OPC_ADD,
  parameter int         WORD_W_P   = WORD_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o,
  output state_e     dbg_state_o
);

  localparam int NB = WORD_W_P / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  // Handshake: a byte moves on a rising edge where valid && ready; a source
  // never retracts or changes a byte while valid is high and ready is low.
  state_e                state_q, state_d;
  logic [7:0]            opc_q, opc_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [WORD_W_P-1:0]   acc_q, acc_d;
  logic [WORD_W_P-1:0]   opnd_q, opnd_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW:0]           ld_cnt_q, ld_cnt_d;
  logic                  err_q, err_d;

  logic                  rx_ready;
  logic                  rx_fire;
  logic                  tx_fire;
  logic                  skid_load;
  logic [7:0]            skid_data;
  logic [15:0]           p_len;
  logic [WORD_W_P-1:0]   opnd_next;
  logic [WORD_W_P-1:0]   acc_shift;

  assign rx_ready_o = rx_ready && !rst;
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_fire    = tx_valid_o && tx_ready_i;

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    len_lo_d  = len_lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    idx_d     = idx_q;
    ld_cnt_d  = ld_cnt_q;
    err_d     = 1'b0;
    rx_ready  = 1'b0;
    skid_load = 1'b0;
    skid_data = rx_data_i;
    p_len     = payload_len({rx_data_i, len_lo_q});
    opnd_next = opnd_q | (WORD_W_P'(rx_data_i) << {idx_q, 3'b000});
    acc_shift = acc_q >> {ld_cnt_q[IW-1:0], 3'b000};

    case (state_q)
      ST_HDR0: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          opc_d   = rx_data_i;
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        rx_ready = 1'b1;
        if (rx_fire) state_d = ST_HDR2;
      end
      ST_HDR2: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          len_lo_d = rx_data_i;
          state_d  = ST_HDR3;
        end
      end
      ST_HDR3: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          cnt_d = p_len;
          if (opc_q == OPC_ECHO_P) begin
            state_d = (p_len == 16'd0) ? ST_HDR0 : ST_ECHO;
          end else if (opc_q == OPC_ADD_P) begin
            acc_d    = '0;
            opnd_d   = '0;
            idx_d    = '0;
            ld_cnt_d = '0;
            state_d  = (p_len == 16'd0) ? ST_ADD_TX : ST_ADD_RX;
          end else begin
            err_d   = 1'b1;
            state_d = (p_len == 16'd0) ? ST_HDR0 : ST_DRAIN;
          end
        end
      end
      ST_ECHO: begin
        rx_ready = !tx_valid_o || tx_ready_i;
        if (rx_fire) begin
          skid_load = 1'b1;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_ECHO_FLUSH;
        end
      end
      ST_ECHO_FLUSH: begin
        if (!tx_valid_o || tx_ready_i) state_d = ST_HDR0;
      end
      ST_ADD_RX: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          idx_d = idx_q + 1'b1;
          cnt_d = cnt_q - 16'd1;
          // A full word or the final (possibly partial) word folds into acc.
          if (idx_q == IW'(NB - 1) || cnt_q == 16'd1) begin
            acc_d  = acc_q + opnd_next;
            opnd_d = '0;
          end else begin
            opnd_d = opnd_next;
          end
          if (cnt_q == 16'd1) state_d = ST_ADD_TX;
        end
      end
      ST_ADD_TX: begin
        if (ld_cnt_q != (IW+1)'(NB)) begin
          if (!tx_valid_o || tx_ready_i) begin
            skid_load = 1'b1;
            skid_data = acc_shift[7:0];
            ld_cnt_d  = ld_cnt_q + 1'b1;
          end
        end else if (tx_fire) begin
          state_d = ST_HDR0;
        end
      end
      ST_DRAIN: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_HDR0;
        end
      end
      default: state_d = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HDR0;
      opc_q    <= '0;
      len_lo_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      idx_q    <= '0;
      ld_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      idx_q    <= idx_d;
      ld_cnt_q <= ld_cnt_d;
      err_q    <= err_d;
    end
  end

  uart_alu_skid #(.W(8)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .data_i  (skid_data),
    .data_o  (tx_data_o),
    .valid_o (tx_valid_o),
    .ready_i (tx_ready_i)
  );

  assign busy_o      = (state_q != ST_HDR0);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for the UART ALU packet controller.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready = 1'b1;
  logic       busy_o;
  logic       err_o;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_viol = 0;
  int ready_viol = 0;
  int stall_cyc = 0;
  int err_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       bp_done = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         tx_cyc_q[$];
  int         rx_cyc_q[$];
  logic [7:0] pkt[$];

  uart_alu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Inputs change only at posedge+1, so negedge sampling sees settled values.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rx_valid && rx_ready_o) rx_cyc_q.push_back(cyc);
      if (tx_valid_o && tx_ready) begin
        got_q.push_back(tx_data_o);
        tx_cyc_q.push_back(cyc);
      end
      if (prev_stall && (!tx_valid_o || tx_data_o != prev_data)) hold_viol++;
      if (tx_valid_o && !tx_ready && rx_ready_o) ready_viol++;
      if (tx_valid_o && !tx_ready) stall_cyc++;
      if (err_o) err_cnt++;
      prev_stall = tx_valid_o && !tx_ready;
      prev_data  = tx_data_o;
    end
  end

  function automatic logic [7:0] got_at(int i);
    return (i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready_o) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout: byte %02h not accepted, rx_ready_o=%b required 1", b, rx_ready_o);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (got_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL tx_wait_timeout: got %0d tx bytes, required %0d", got_q.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    tx_cyc_q.delete();
    rx_cyc_q.delete();
    hold_viol  = 0;
    ready_viol = 0;
    stall_cyc  = 0;
    err_cnt    = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b required 0", rx_ready_o); end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h required 00", tx_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_rx_ready: got %b required 1", rx_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b required 0", busy_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_echo();
    int lat;
    int base;
    clear_mon();
    tx_ready = 1'b1;
    pkt = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_seq(pkt);
    wait_tx(3);
    exp_q = {8'h41, 8'h42, 8'h43};
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL echo_count: got %0d bytes required 3", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL echo_data[%0d]: got %02h required %02h", i, got_at(i), exp_q[i]); end
    end
    base = rx_cyc_q.size() - 3;
    for (int i = 0; i < 3; i++) begin
      lat = (i < tx_cyc_q.size() && base + i >= 0) ? tx_cyc_q[i] - rx_cyc_q[base + i] : -1;
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL echo_latency[%0d]: got %0d cycles required 1", i, lat); end
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL echo_busy_end: got %b required 0", busy_o); end
  endtask

  task automatic test_add();
    clear_mon();
    tx_ready = 1'b1;
    pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_seq(pkt);
    wait_tx(4);
    exp_q = {8'h00, 8'h00, 8'h00, 8'h00};
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL add_wrap_count: got %0d bytes required 4", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL add_wrap[%0d]: got %02h required %02h", i, got_at(i), exp_q[i]); end
    end
    clear_mon();
    pkt = {8'hA0, 8'h00, 8'h0B, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    send_seq(pkt);
    wait_tx(4);
    exp_q = {8'h12, 8'h00, 8'h00, 8'h00};
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL add_partial_count: got %0d bytes required 4", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL add_partial[%0d]: got %02h required %02h", i, got_at(i), exp_q[i]); end
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL add_busy_end: got %b required 0", busy_o); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    bp_done  = 1'b0;
    tx_ready = 1'b0;
    fork
      begin
        pkt = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h61, 8'h62, 8'h63};
        send_seq(pkt);
        wait_tx(3);
        bp_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!bp_done) begin
          @(posedge clk);
          #1;
          k++;
          if (k % 2 == 0) tx_ready = !tx_ready;
        end
      end
    join
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q = {8'h61, 8'h62, 8'h63};
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d bytes required 3", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %02h required %02h", i, got_at(i), exp_q[i]); end
    end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stall cycles required 0", hold_viol); end
    checks++; if (ready_viol !== 0) begin errors++; $display("FAIL bp_rx_ready: got %0d cycles ready while full required 0", ready_viol); end
    checks++; if (stall_cyc == 0) begin errors++; $display("FAIL bp_stalled: got %0d stall cycles required >0", stall_cyc); end
  endtask

  task automatic test_unknown();
    clear_mon();
    tx_ready = 1'b1;
    pkt = {8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    send_seq(pkt);
    wait_tx(1);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL unk_err_pulse: got %0d err cycles required 1", err_cnt); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL unk_tx_count: got %0d bytes required 1", got_q.size()); end
    checks++; if (got_at(0) !== 8'h99) begin errors++; $display("FAIL unk_tx_data: got %02h required 99", got_at(0)); end
  endtask

  task automatic test_boundary();
    clear_mon();
    tx_ready = 1'b1;
    pkt = {8'hA0, 8'h00, 8'h02, 8'h00};
    send_seq(pkt);
    wait_tx(4);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL bnd_add_count: got %0d bytes required 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_at(i) !== 8'h00) begin errors++; $display("FAIL bnd_add[%0d]: got %02h required 00", i, got_at(i)); end
    end
    clear_mon();
    pkt = {8'hEC, 8'h00, 8'h04, 8'h00};
    send_seq(pkt);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL bnd_echo_empty: got %0d bytes required 0", got_q.size()); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bnd_echo_busy: got %b required 0", busy_o); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL bnd_no_err: got %0d err cycles required 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    tx_ready = 1'b0;
    pkt = {8'hEC, 8'h00, 8'h08, 8'h00, 8'h11};
    send_seq(pkt);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (tx_valid_o !== 1'b1) begin errors++; $display("FAIL mid_held: got tx_valid %b required 1", tx_valid_o); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b required 0", tx_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", busy_o); end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    pkt = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h22};
    send_seq(pkt);
    wait_tx(1);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_tx_count: got %0d bytes required 1", got_q.size()); end
    checks++; if (got_at(0) !== 8'h22) begin errors++; $display("FAIL mid_tx_data: got %02h required 22", got_at(0)); end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_add();
    test_backpressure();
    test_unknown();
    test_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
